ref_pix_ar_scheduler: RTL
=========================

Name: ref_pix_ar_scheduler

Overview:
- Schedules AXI read-address requests for reference-pixel cache-line misses.
- Pops miss addresses from the AR-address FIFO that the tag-compare stage fills, presents each one on the AXI AR channel, and caps in-flight bursts with a credit counter.
- Provides a flush/drain handshake so the pipeline can quiesce memory traffic before a ref-picture or cache reset.

Parameters:
- AXI_ADDR_WDTH, 32, AXI byte-address width.
- MAX_OUTSTANDING, 4, maximum AR bursts issued without a matching R last beat (1..15).
- BURST_LEN, 8, beats per cache-line fill; arlen = BURST_LEN-1.
- OUT_CNT_WDTH, 4, width of outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ar_fifo_empty  in  1  miss AR-address FIFO empty.
- ar_fifo_rd_en  out  1  one-cycle pop strobe to FIFO.
- ar_fifo_dout  in  AXI_ADDR_WDTH  FIFO data, valid the cycle after ar_fifo_rd_en.
- axi_arvalid  out  1  AXI AR valid.
- axi_araddr  out  AXI_ADDR_WDTH  AXI AR address.
- axi_arlen  out  8  constant BURST_LEN-1.
- axi_arready  in  1  AXI AR ready.
- r_last_hs  in  1  rvalid&rready&rlast of the ref-pix R channel.
- flush_req  in  1  level request: stop issuing and drain.
- flush_done  out  1  high while in DRAIN with zero outstanding and no AR pending.
- outstanding_cnt  out  OUT_CNT_WDTH  bursts in flight.
- sched_idle  out  1  FSM in IDLE and outstanding_cnt==0.
- credit_err  out  1  sticky: r_last_hs seen with outstanding_cnt==0.

Behaviour:
- Reset (reset=0, async):
  - ar_fifo_rd_en=0, axi_arvalid=0, axi_araddr=0.
  - outstanding_cnt=0, flush_done=0, credit_err=0, sched_idle=1.
  - FSM=IDLE.
- State IDLE:
  - flush_req=1 -> DRAIN.
  - Else if !ar_fifo_empty and outstanding_cnt<MAX_OUTSTANDING: ar_fifo_rd_en=1 for exactly one cycle -> LOAD.
  - Else stay.
- State LOAD (one cycle): axi_araddr<=ar_fifo_dout; axi_arvalid<=1 -> ISSUE.
- State ISSUE:
  - axi_arvalid and axi_araddr held stable until axi_arready=1.
  - On handshake: axi_arvalid<=0, outstanding_cnt+1.
  - Next state is DRAIN if flush_req=1. Otherwise, if !ar_fifo_empty and (outstanding_cnt+1)<MAX_OUTSTANDING, pulse ar_fifo_rd_en in the same cycle -> LOAD (back-to-back, 2 cycles/request). Else -> IDLE.
- State DRAIN:
  - No pops, no AR issue.
  - flush_done=1 when outstanding_cnt==0.
  - flush_req=0 -> IDLE.
- Flush during LOAD/ISSUE: an AR already loaded is never withdrawn; it completes its handshake, then goes to DRAIN.
- Latency: FIFO non-empty in IDLE -> arvalid asserted 2 cycles later, i.e. rd_en at cycle N, arvalid at N+2.
- Credit counter:
  - +1 on AR handshake, -1 on r_last_hs; both in the same cycle -> unchanged.
  - Never exceeds MAX_OUTSTANDING: no pop when at limit. A pending AR always has a reserved credit.
  - r_last_hs at 0 -> count stays 0, credit_err<=1 (cleared only by reset).
- axi_arlen is constant; axi_araddr changes only in LOAD.
- ar_fifo_rd_en is never asserted while ar_fifo_empty=1.
- sched_idle is combinational from state and count.

Test Plan:
- Reset mid-ISSUE (arvalid=1, arready=0): deassert reset -> all outputs at reset values, FSM IDLE, outstanding_cnt=0.
- Single miss 0x0004_2000 with arready=1 immediately:
  - rd_en at cycle 1; arvalid=1 with araddr=0x0004_2000 and arlen=7 at cycle 3.
  - outstanding_cnt=1 at cycle 4.
  - r_last_hs then -> 0, sched_idle=1.
- 6 FIFO entries, no R returns, MAX_OUTSTANDING=4: exactly 4 ARs issued at 2-cycle spacing, rd_en silent afterwards. One r_last_hs -> 5th AR issued.
- arready held low 10 cycles: araddr/arvalid stable throughout; handshake on cycle 11 only; no extra pop.
- Simultaneous AR handshake and r_last_hs with count=2 -> count stays 2.
- flush_req raised during ISSUE with count=1: AR completes (count=2), FSM DRAIN, no pops, flush_done=0. After two r_last_hs, flush_done=1. Drop flush_req -> IDLE resumes popping.
- r_last_hs with count=0 -> credit_err=1, count stays 0.

Source files
------------

// File: rtl/ref_pix_ar_scheduler.sv
// ---------------------------------------------------------------------------
// ref_pix_ar_scheduler
//
// Issues AXI read-address requests for reference-pixel cache-line misses.
// Miss addresses are popped from the AR-address FIFO that the tag-compare
// stage fills, then presented on the AXI AR channel. A credit counter caps
// the number of bursts in flight. A flush/drain handshake lets the pipeline
// quiesce memory traffic before a ref-picture switch or a cache reset.
//
// Ports
//   clk_i              clock, rising edge
//   reset_ni           asynchronous reset, active low
//   ar_fifo_empty_i    miss FIFO empty
//   ar_fifo_rd_en_o    one-cycle pop strobe to the miss FIFO
//   ar_fifo_dout_i     FIFO data, valid the cycle after the pop strobe
//   axi_arvalid_o      AXI AR valid
//   axi_araddr_o       AXI AR address
//   axi_arlen_o        AXI AR burst length (BURST_LEN-1, constant)
//   axi_arready_i      AXI AR ready
//   r_last_hs_i        rvalid & rready & rlast of the ref-pix R channel
//   flush_req_i        level request: stop issuing and drain
//   flush_done_o       draining, nothing in flight, no AR pending
//   outstanding_cnt_o  bursts in flight
//   sched_idle_o       FSM idle and nothing in flight
//   credit_err_o       sticky: R last beat arrived with nothing in flight
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for a miss with a free credit, or for a flush
//   ST_LOAD  | FIFO data valid this cycle; capture it into the AR register
//   ST_ISSUE | AR presented, waiting for arready
//   ST_DRAIN | flush requested; no pops, no issue, wait for R returns
// ---------------------------------------------------------------------------
module ref_pix_ar_scheduler #(
   parameter int AXI_ADDR_WDTH   = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int BURST_LEN       = 8,
   parameter int OUT_CNT_WDTH    = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     ar_fifo_empty_i,
   output logic                     ar_fifo_rd_en_o,
   input  logic [AXI_ADDR_WDTH-1:0] ar_fifo_dout_i,
   output logic                     axi_arvalid_o,
   output logic [AXI_ADDR_WDTH-1:0] axi_araddr_o,
   output logic [7:0]               axi_arlen_o,
   input  logic                     axi_arready_i,
   input  logic                     r_last_hs_i,
   input  logic                     flush_req_i,
   output logic                     flush_done_o,
   output logic [OUT_CNT_WDTH-1:0]  outstanding_cnt_o,
   output logic                     sched_idle_o,
   output logic                     credit_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   localparam logic [OUT_CNT_WDTH:0]   MAX_C   = (OUT_CNT_WDTH+1)'(MAX_OUTSTANDING);
   localparam logic [OUT_CNT_WDTH:0]   ONE_X_C = {{OUT_CNT_WDTH{1'b0}}, 1'b1};
   localparam logic [OUT_CNT_WDTH-1:0] ONE_C   = {{(OUT_CNT_WDTH-1){1'b0}}, 1'b1};
   localparam logic [7:0]              ARLEN_C = 8'(BURST_LEN - 1);

   state_e                     state_q, state_d;
   logic [OUT_CNT_WDTH-1:0]    cnt_q, cnt_d;
   logic                       arvalid_q, arvalid_d;
   logic [AXI_ADDR_WDTH-1:0]   araddr_q, araddr_d;
   logic                       credit_err_q, credit_err_d;
   logic                       rd_en;

   logic                       ar_hs;
   logic                       r_dec;
   logic [OUT_CNT_WDTH:0]      cnt_ext;
   logic [OUT_CNT_WDTH:0]      cnt_plus1;
   logic                       can_pop_idle;
   logic                       can_pop_issue;

   assign ar_hs     = arvalid_q & axi_arready_i;
   // An R last beat with nothing in flight is an error, not a credit return.
   assign r_dec     = r_last_hs_i & (cnt_q != '0);
   assign cnt_ext   = {1'b0, cnt_q};
   assign cnt_plus1 = cnt_ext + ONE_X_C;

   // A pop reserves the credit for the AR it will produce. From ISSUE the
   // AR being handshaken already holds one, so the next pop needs count+1.
   assign can_pop_idle  = cnt_ext < MAX_C;
   assign can_pop_issue = cnt_plus1 < MAX_C;

   always_comb begin
      cnt_d        = cnt_q;
      credit_err_d = credit_err_q;
      if (ar_hs && !r_dec) begin
         cnt_d = cnt_q + ONE_C;
      end else if (!ar_hs && r_dec) begin
         cnt_d = cnt_q - ONE_C;
      end
      if (r_last_hs_i && (cnt_q == '0)) begin
         credit_err_d = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_en     = 1'b0;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (flush_req_i) begin
               state_d = ST_DRAIN;
            end else if (!ar_fifo_empty_i && can_pop_idle) begin
               rd_en   = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            araddr_d  = ar_fifo_dout_i;
            arvalid_d = 1'b1;
            state_d   = ST_ISSUE;
         end
         ST_ISSUE: begin
            // A loaded AR is never withdrawn; a flush only takes effect
            // once it has been accepted.
            if (ar_hs) begin
               arvalid_d = 1'b0;
               if (flush_req_i) begin
                  state_d = ST_DRAIN;
               end else if (!ar_fifo_empty_i && can_pop_issue) begin
                  rd_en   = 1'b1;
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            if (!flush_req_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         arvalid_q    <= 1'b0;
         araddr_q     <= '0;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         arvalid_q    <= arvalid_d;
         araddr_q     <= araddr_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign ar_fifo_rd_en_o   = rd_en;
   assign axi_arvalid_o     = arvalid_q;
   assign axi_araddr_o      = araddr_q;
   assign axi_arlen_o       = ARLEN_C;
   assign outstanding_cnt_o = cnt_q;
   assign credit_err_o      = credit_err_q;
   assign flush_done_o      = (state_q == ST_DRAIN) && (cnt_q == '0) && !arvalid_q;
   assign sched_idle_o      = (state_q == ST_IDLE) && (cnt_q == '0);

endmodule
